// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: accepts two NDIG-digit BCD operands and a carry-in,
// adds one decimal digit per clock, and presents the result through a valid/ready handshake.
module bcd_serial_adder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
  logic [IW-1:0]   idx_r;

  logic [IW+1:0]   base_s;
  logic [3:0]      a_dig_s;
  logic [3:0]      b_dig_s;
  logic [4:0]      add_s;
  logic            digit_err_s;

  // One decimal digit: returns {carry, digit}; binary sums above 9 are corrected by +6.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                               input logic c);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, x} + {1'b0, y} + {4'd0, c};
    adj = s + 5'd6;
    if (s > 5'd9) begin
      bcd_digit_add = {1'b1, adj[3:0]};
    end else begin
      bcd_digit_add = {1'b0, s[3:0]};
    end
  endfunction

  function automatic logic digit_invalid(input logic [3:0] d);
    digit_invalid = (d > 4'd9);
  endfunction

  // Select the current digit pair and form its decimal sum and error flag.
  always_comb begin
    base_s      = {idx_r, 2'b00};
    a_dig_s     = a_r[base_s +: 4];
    b_dig_s     = b_r[base_s +: 4];
    add_s       = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
    digit_err_s = digit_invalid(a_dig_s) | digit_invalid(b_dig_s);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx_r     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry_r  <= cin;
            idx_r    <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            state_r  <= ADD;
          end else begin
            state_r  <= IDLE;
          end
        end
        ADD: begin
          sum[base_s +: 4] <= add_s[3:0];
          carry_r          <= add_s[4];
          err              <= err | digit_err_s;
          if (idx_r == LAST_IDX) begin
            cout      <= add_s[4];
            idx_r     <= '0;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            idx_r     <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          // Release only; acceptance of the next operand waits for the following cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          idx_r     <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed BCD cases, backpressure,
// mid-transaction reset and randomized operands against a digit-wise decimal model.
module tb_bcd_serial_adder;

  localparam int NDIG = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int tests;
  int fails;

  bcd_serial_adder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal addition digit by digit, with the +6 correction for sums above 9.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                       output logic [15:0] ms, output logic mco, output logic me);
    int c;
    int da;
    int db;
    int s;
    c  = int'(mc);
    ms = 16'h0000;
    me = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      da = (int'(ma) >> (4 * i)) % 16;
      db = (int'(mb) >> (4 * i)) % 16;
      if (da > 9 || db > 9) me = 1'b1;
      s = da + db + c;
      if (s > 9) begin
        s = (s + 6) % 16;
        c = 1;
      end else begin
        c = 0;
      end
      ms = ms | 16'(s << (4 * i));
    end
    mco = c[0];
  endtask

  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input int hold, input string name);
    logic [15:0] es;
    logic        ec;
    logic        ee;
    int          lat;
    int          w;
    model(ta, tb_, tc, es, ec, ee);
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready: in_ready=%b required 1", name, in_ready);
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    tests++;
    if (lat != NDIG) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, NDIG);
    end
    tests++;
    if (sum !== es || cout !== ec || err !== ee || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s result: sum=%h cout=%b err=%b in_ready=%b required sum=%h cout=%b err=%b in_ready=0",
               name, sum, cout, err, in_ready, es, ec, ee);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || sum !== es || cout !== ec || err !== ee) begin
        fails++;
        $display("FAIL %s hold%0d: valid=%b sum=%h cout=%b err=%b required valid=1 sum=%h cout=%b err=%b",
                 name, k, out_valid, sum, cout, err, es, ec, ee);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ov=%b ir=%b sum=%h cout=%b err=%b required 0/1/0000/0/0",
               out_valid, in_ready, sum, cout, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: ov=%b ir=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    run_txn(16'h0069, 16'h0099, 1'b0, 0, "d_0069_0099");
    run_txn(16'h9999, 16'h0001, 1'b0, 0, "d_9999_0001");
    run_txn(16'h0033, 16'h0033, 1'b1, 0, "d_0033_0033_c1");
    run_txn(16'h0000, 16'h0000, 1'b0, 0, "d_zero");
    run_txn(16'h000A, 16'h0000, 1'b0, 0, "d_err_000A");
    run_txn(16'h0001, 16'h0001, 1'b0, 0, "d_err_cleared");
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, "d_all_F");
  endtask

  task automatic test_backpressure();
    run_txn(16'h1234, 16'h8766, 1'b0, 10, "bp_hold10");
  endtask

  task automatic test_mid_reset();
    a = 16'h9999; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: ov=%b ir=%b sum=%h cout=%b err=%b required 0/1/0000/0/0",
               out_valid, in_ready, sum, cout, err);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_no_valid%0d: out_valid=%b required 0", k, out_valid);
      end
    end
    run_txn(16'h0045, 16'h0055, 1'b0, 0, "after_reset_0045_0055");
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 3) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end else begin
        ra = 16'h0000;
        rb = 16'h0000;
        for (int i = 0; i < NDIG; i++) begin
          ra = ra | 16'($urandom_range(0, 9) << (4 * i));
          rb = rb | 16'($urandom_range(0, 9) << (4 * i));
        end
      end
      run_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
      tests++;
      if ($isunknown({in_ready, out_valid, sum, cout, err})) begin
        fails++;
        $display("FAIL rand%0d_x: outputs=%b required no X", n, {in_ready, out_valid, sum, cout, err});
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand (NDIG >= 1).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the operand set on a/b/cin is valid.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operand set.
REQ-006 SHALL have port a  input  4*NDIG  BCD operand A; digit 0 is in bits [3:0] and is the least significant digit.
REQ-007 SHALL have port b  input  4*NDIG  BCD operand B, with the same digit layout as a.
REQ-008 SHALL have port cin  input  1  carry into digit 0.
REQ-009 SHALL have port out_valid  output  1  a result is presented on sum/cout/err.
REQ-010 SHALL have port out_ready  input  1  the downstream consumer accepts the result.
REQ-011 SHALL have port sum  output  4*NDIG  BCD result, with the same digit layout as a.
REQ-012 SHALL have port cout  output  1  decimal carry out of digit NDIG-1.
REQ-013 SHALL have port err  output  1  at least one input digit of the transaction was greater than 9.

Function
REQ-014 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and drive out_valid = 1 only in DONE.
REQ-016 SHALL accept an operand set on a clock edge where in_valid && in_ready.
- Latches a and b, loads the carry register with cin, clears the digit index and clears err.
- Moves to ADD.
REQ-017 SHALL, in IDLE with in_valid = 0, hold all state and outputs.
REQ-018 SHALL process exactly one digit i per ADD cycle, in order i = 0 to NDIG-1.
- Computes s = a_i + b_i + carry as a 5-bit unsigned value.
- If s > 9: sum_i = (s + 6) mod 16 and carry = 1.
- Otherwise: sum_i = s and carry = 0.
REQ-019 SHALL set err sticky (for the rest of the transaction) when the digit being processed has a_i > 9 or b_i > 9, and SHALL still compute that digit per REQ-018.
REQ-020 SHALL increment the digit index after each ADD cycle, and on the edge that processes digit NDIG-1 SHALL load cout from the carry and move to DONE.
REQ-021 SHALL assert out_valid exactly NDIG clock cycles after the acceptance edge; the latency is fixed and independent of the data.
REQ-022 SHALL hold sum, cout and err stable while out_valid = 1.
REQ-023 SHALL remain in DONE while out_ready = 0, for unbounded backpressure with no loss of the result.
REQ-024 SHALL move from DONE to IDLE on an edge where out_ready = 1; in_ready SHALL go high in the following cycle, so there is no accept on the same edge as the release.
REQ-025 SHALL ignore in_valid, a, b and cin while in ADD or DONE; changes to these inputs in those states SHALL NOT affect the result.
REQ-026 SHALL leave sum, cout and err holding the last result when in IDLE; these values carry no meaning while out_valid = 0.
REQ-027 SHALL generate no X on any output after reset, for any input values, including the case where all digits equal 15.

Reset
REQ-028 SHALL, on a clock edge with rst = 1, force the state to IDLE and clear sum, cout, err, the carry register and the digit index to 0.
REQ-029 SHALL take rst = 1 over all other events, including a reset asserted mid-ADD or in DONE; the in-flight transaction is discarded and no out_valid pulse is produced for it.
REQ-030 SHALL drive out_valid = 0 and in_ready = 1 in the first cycle after rst is released.

Verification
REQ-031 Bench SHALL cover: a=0069, b=0099, cin=0 -> sum=0168, cout=0, err=0, with out_valid asserted 4 cycles after acceptance.
REQ-032 Bench SHALL cover: a=9999, b=0001, cin=0 -> sum=0000, cout=1, err=0.
REQ-033 Bench SHALL cover: a=0033, b=0033, cin=1 -> sum=0067, cout=0; and a=0000, b=0000, cin=0 -> sum=0000, cout=0.
REQ-034 Bench SHALL cover: a=000A, b=0000, cin=0 -> sum=0010, cout=0, err=1; then a=0001, b=0001 -> sum=0002, err=0, confirming err is cleared per transaction.
REQ-035 Bench SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid held and sum stable throughout; when out_ready rises -> IDLE, with in_ready = 1 on the next cycle.
REQ-036 Bench SHALL cover: rst asserted for 1 cycle during the 2nd ADD cycle -> no out_valid, all outputs 0, in_ready = 1 after release; the next transaction 0045+0055 -> sum=0100, cout=0.
